// File: rtl/butterfly_pipe.sv
// Three-stage pipelined radix-2 DIT butterfly (A +/- B*W) with a valid/ready stream interface.
// Define BUTTERFLY_SAT_EN to clamp overflowing outputs; by default they wrap.
module butterfly_pipe #(
    parameter int unsigned DATA_WIDTH = 21,
    parameter int unsigned FRAC_BITS  = 15
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [2*DATA_WIDTH-1:0] twid_i,
    input  logic [2*DATA_WIDTH-1:0] a_i,
    input  logic [2*DATA_WIDTH-1:0] b_i,
    input  logic                    inv_i,
    input  logic                    scale_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [2*DATA_WIDTH-1:0] a_o,
    output logic [2*DATA_WIDTH-1:0] b_o,
    output logic                    ovf_o,
    output logic                    ovf_sticky_o
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned CW = 2 * DW;
    localparam int unsigned WW = DW + 1;
    localparam int unsigned PW = 2 * DW + 1;
    localparam int unsigned AW = PW + 1;
    localparam int unsigned SW = DW + 3;

    localparam logic signed [AW-1:0] RND   = AW'(2 ** (FRAC_BITS - 1));
    localparam logic signed [SW-1:0] MAX_V = SW'((2 ** (DW - 1)) - 1);
    localparam logic signed [SW-1:0] MIN_V = SW'(-(2 ** (DW - 1)));

    // Round-half-up divide by two when enabled.
    function automatic logic signed [SW-1:0] halve(input logic signed [SW-1:0] x, input logic en);
        return en ? ((x + SW'(1)) >>> 1) : x;
    endfunction

    // Reduce to DW bits; MSB of the result is the overflow flag.
    function automatic logic [DW:0] fit(input logic signed [SW-1:0] x);
        logic          ovf;
        logic [DW-1:0] v;
        ovf = (x > MAX_V) || (x < MIN_V);
`ifdef BUTTERFLY_SAT_EN
        if (x > MAX_V)      v = DW'(MAX_V);
        else if (x < MIN_V) v = DW'(MIN_V);
        else                v = DW'(x);
`else
        v = DW'(x);
`endif
        return {ovf, v};
    endfunction

    logic                 s1_valid_q, s1_valid_d;
    logic [CW-1:0]        s1_a_q, s1_a_d;
    logic signed [DW-1:0] s1_br_q, s1_br_d, s1_bi_q, s1_bi_d;
    logic signed [WW-1:0] s1_wr_q, s1_wr_d, s1_wi_q, s1_wi_d;
    logic                 s1_scale_q, s1_scale_d;

    logic                 s2_valid_q, s2_valid_d;
    logic [CW-1:0]        s2_a_q, s2_a_d;
    logic signed [PW-1:0] s2_rr_q, s2_rr_d, s2_ii_q, s2_ii_d;
    logic signed [PW-1:0] s2_ri_q, s2_ri_d, s2_ir_q, s2_ir_d;
    logic                 s2_scale_q, s2_scale_d;

    logic                 out_valid_q, out_valid_d;
    logic [CW-1:0]        a_out_q, a_out_d, b_out_q, b_out_d;
    logic                 ovf_q, ovf_d;
    logic                 sticky_q, sticky_d;

    logic                 adv_c;
    logic signed [WW-1:0] tw_im_c;
    logic signed [AW-1:0] acc_re_c, acc_im_c;
    logic signed [SW-1:0] rot_re_c, rot_im_c, a_re_c, a_im_c;
    logic [DW:0]          fit_ar_c, fit_ai_c, fit_br_c, fit_bi_c;

    assign adv_c        = !out_valid_q || out_ready_i;
    assign in_ready_o   = adv_c;
    assign out_valid_o  = out_valid_q;
    assign a_o          = a_out_q;
    assign b_o          = b_out_q;
    assign ovf_o        = ovf_q;
    assign ovf_sticky_o = sticky_q;

    // Stage 3 arithmetic: rounded rotation, add/subtract, optional halving, reduction.
    always_comb begin
        acc_re_c = AW'(s2_rr_q) - AW'(s2_ii_q) + RND;
        acc_im_c = AW'(s2_ri_q) + AW'(s2_ir_q) + RND;
        rot_re_c = SW'(acc_re_c >>> FRAC_BITS);
        rot_im_c = SW'(acc_im_c >>> FRAC_BITS);
        a_re_c   = SW'($signed(s2_a_q[DW-1:0]));
        a_im_c   = SW'($signed(s2_a_q[CW-1:DW]));
        fit_ar_c = fit(halve(a_re_c + rot_re_c, s2_scale_q));
        fit_ai_c = fit(halve(a_im_c + rot_im_c, s2_scale_q));
        fit_br_c = fit(halve(a_re_c - rot_re_c, s2_scale_q));
        fit_bi_c = fit(halve(a_im_c - rot_im_c, s2_scale_q));
    end

    // Next-state for all stages; everything holds unless the pipe advances.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_br_d     = s1_br_q;
        s1_bi_d     = s1_bi_q;
        s1_wr_d     = s1_wr_q;
        s1_wi_d     = s1_wi_q;
        s1_scale_d  = s1_scale_q;
        s2_valid_d  = s2_valid_q;
        s2_a_d      = s2_a_q;
        s2_rr_d     = s2_rr_q;
        s2_ii_d     = s2_ii_q;
        s2_ri_d     = s2_ri_q;
        s2_ir_d     = s2_ir_q;
        s2_scale_d  = s2_scale_q;
        out_valid_d = out_valid_q;
        a_out_d     = a_out_q;
        b_out_d     = b_out_q;
        ovf_d       = ovf_q;
        sticky_d    = sticky_q | (out_valid_q & out_ready_i & ovf_q);
        tw_im_c     = WW'($signed(twid_i[CW-1:DW]));

        if (adv_c) begin
            s1_valid_d  = in_valid_i;
            s2_valid_d  = s1_valid_q;
            out_valid_d = s2_valid_q;
            if (in_valid_i) begin
                s1_a_d     = a_i;
                s1_br_d    = $signed(b_i[DW-1:0]);
                s1_bi_d    = $signed(b_i[CW-1:DW]);
                s1_wr_d    = WW'($signed(twid_i[DW-1:0]));
                s1_wi_d    = inv_i ? -tw_im_c : tw_im_c;
                s1_scale_d = scale_i;
            end
            if (s1_valid_q) begin
                s2_a_d     = s1_a_q;
                s2_rr_d    = PW'(s1_br_q) * PW'(s1_wr_q);
                s2_ii_d    = PW'(s1_bi_q) * PW'(s1_wi_q);
                s2_ri_d    = PW'(s1_br_q) * PW'(s1_wi_q);
                s2_ir_d    = PW'(s1_bi_q) * PW'(s1_wr_q);
                s2_scale_d = s1_scale_q;
            end
            if (s2_valid_q) begin
                a_out_d = {fit_ai_c[DW-1:0], fit_ar_c[DW-1:0]};
                b_out_d = {fit_bi_c[DW-1:0], fit_br_c[DW-1:0]};
                ovf_d   = fit_ar_c[DW] | fit_ai_c[DW] | fit_br_c[DW] | fit_bi_c[DW];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_br_q     <= '0;
            s1_bi_q     <= '0;
            s1_wr_q     <= '0;
            s1_wi_q     <= '0;
            s1_scale_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_a_q      <= '0;
            s2_rr_q     <= '0;
            s2_ii_q     <= '0;
            s2_ri_q     <= '0;
            s2_ir_q     <= '0;
            s2_scale_q  <= 1'b0;
            out_valid_q <= 1'b0;
            a_out_q     <= '0;
            b_out_q     <= '0;
            ovf_q       <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_br_q     <= s1_br_d;
            s1_bi_q     <= s1_bi_d;
            s1_wr_q     <= s1_wr_d;
            s1_wi_q     <= s1_wi_d;
            s1_scale_q  <= s1_scale_d;
            s2_valid_q  <= s2_valid_d;
            s2_a_q      <= s2_a_d;
            s2_rr_q     <= s2_rr_d;
            s2_ii_q     <= s2_ii_d;
            s2_ri_q     <= s2_ri_d;
            s2_ir_q     <= s2_ir_d;
            s2_scale_q  <= s2_scale_d;
            out_valid_q <= out_valid_d;
            a_out_q     <= a_out_d;
            b_out_q     <= b_out_d;
            ovf_q       <= ovf_d;
            sticky_q    <= sticky_d;
        end
    end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Bench for butterfly_pipe: directed literal cases plus a randomized stream against a reference model.
module tb_butterfly_pipe;

    localparam int DW = 21;
    localparam int FB = 15;
    localparam int CW = 2 * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic          inv = 1'b0;
    logic          scale = 1'b0;
    logic [CW-1:0] twid = '0;
    logic [CW-1:0] a = '0;
    logic [CW-1:0] b = '0;
    logic          in_ready, out_valid, ovf, ovf_sticky;
    logic [CW-1:0] a_o, b_o;

    butterfly_pipe #(.DATA_WIDTH(DW), .FRAC_BITS(FB)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .twid_i(twid), .a_i(a), .b_i(b), .inv_i(inv), .scale_i(scale),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .a_o(a_o), .b_o(b_o),
        .ovf_o(ovf), .ovf_sticky_o(ovf_sticky)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] a;
        logic [CW-1:0] b;
        logic          ovf;
    } res_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_pop = 0;
    int   n_not_ready = 0;
    res_t exp_q[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [CW-1:0] cplx(input int re, input int im);
        return {DW'(im), DW'(re)};
    endfunction

    function automatic longint sx(input logic [DW-1:0] v);
        return longint'($signed(v));
    endfunction

    // Reference butterfly in plain 64-bit integer arithmetic.
    function automatic res_t model(input logic [CW-1:0] av, bv, wv, input logic iv, sv);
        longint        ar, ai, br, bi, wr, wi, rr, ri, half, maxv, minv;
        longint        x[4];
        logic [DW-1:0] y[4];
        res_t          r;
        ar = sx(av[DW-1:0]);  ai = sx(av[CW-1:DW]);
        br = sx(bv[DW-1:0]);  bi = sx(bv[CW-1:DW]);
        wr = sx(wv[DW-1:0]);  wi = sx(wv[CW-1:DW]);
        if (iv) wi = -wi;
        half = longint'(1) << (FB - 1);
        maxv = (longint'(1) << (DW - 1)) - 1;
        minv = -(longint'(1) << (DW - 1));
        rr = (br * wr - bi * wi + half) >>> FB;
        ri = (br * wi + bi * wr + half) >>> FB;
        x[0] = ar + rr;  x[1] = ai + ri;
        x[2] = ar - rr;  x[3] = ai - ri;
        r.ovf = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (sv) x[k] = (x[k] + 1) >>> 1;
            if (x[k] > maxv || x[k] < minv) r.ovf = 1'b1;
`ifdef BUTTERFLY_SAT_EN
            if (x[k] > maxv) x[k] = maxv;
            if (x[k] < minv) x[k] = minv;
`endif
            y[k] = DW'(x[k]);
        end
        r.a = {y[1], y[0]};
        r.b = {y[3], y[2]};
        return r;
    endfunction

    // Compare process: scoreboard, handshake rule and stall stability, sampled mid-cycle.
    logic          held_v = 1'b0;
    logic [CW-1:0] held_a, held_b;
    logic          held_ovf;
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            exp_q.delete();
            held_v = 1'b0;
        end else begin
            check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (!in_ready) n_not_ready++;
            if (held_v) begin
                check("stall_valid", 64'(out_valid), 64'(1));
                check("stall_a", 64'(a_o), 64'(held_a));
                check("stall_b", 64'(b_o), 64'(held_b));
                check("stall_ovf", 64'(ovf), 64'(held_ovf));
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, twid, inv, scale));
            if (out_valid && out_ready) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: a_o=0x%0h b_o=0x%0h with no beat outstanding at %0t", a_o, b_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_a", 64'(a_o), 64'(e.a));
                    check("sb_b", 64'(b_o), 64'(e.b));
                    check("sb_ovf", 64'(ovf), 64'(e.ovf));
                end
            end
            held_v   = out_valid && !out_ready;
            held_a   = a_o;
            held_b   = b_o;
            held_ovf = ovf;
        end
    end

    // Present one beat (called #1 after a rising edge); returns #1 after the accepting edge.
    task automatic drive_beat(input logic [CW-1:0] av, bv, wv, input logic iv, sv);
        logic acc;
        a = av; b = bv; twid = wv; inv = iv; scale = sv; in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        n_vec++;
        n_err++;
        $display("FAIL drive_timeout: in_ready stayed 0 for 200 cycles, expected 1");
    endtask

    // Single beat into an idle pipe with literal expected results and latency.
    task automatic direct(input string nm, input logic [CW-1:0] av, bv, wv, input logic iv, sv,
                          input logic [CW-1:0] ea, eb, input logic eo);
        a = av; b = bv; twid = wv; inv = iv; scale = sv; in_valid = 1'b1;
        check({nm, "_ready"}, 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({nm, "_lat1"}, 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        check({nm, "_lat2"}, 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        check({nm, "_lat3"}, 64'(out_valid), 64'(1));
        check({nm, "_a"}, 64'(a_o), 64'(ea));
        check({nm, "_b"}, 64'(b_o), 64'(eb));
        check({nm, "_ovf"}, 64'(ovf), 64'(eo));
        @(posedge clk); #1;
    endtask

    function automatic logic [CW-1:0] rand_data();
        int re, im;
        re = int'($urandom_range(0, 2097151)) - 1048576;
        im = int'($urandom_range(0, 2097151)) - 1048576;
        return cplx(re, im);
    endfunction

    // Twiddles kept inside the unit circle, as a real twiddle ROM would supply.
    function automatic logic [CW-1:0] rand_twid();
        int re, im;
        re = int'($urandom_range(0, 46340)) - 23170;
        im = int'($urandom_range(0, 46340)) - 23170;
        return cplx(re, im);
    endfunction

    logic [CW-1:0] w1;
    logic [CW-1:0] a4_exp;
    int            pop0;
    bit            done;

    initial begin
        w1 = cplx(30274, -12540);
`ifdef BUTTERFLY_SAT_EN
        a4_exp = cplx(1048575, 0);
`else
        a4_exp = cplx(-2, 0);
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_a_o", 64'(a_o), 64'(0));
        check("rst_b_o", 64'(b_o), 64'(0));
        check("rst_ovf", 64'(ovf), 64'(0));
        check("rst_sticky", 64'(ovf_sticky), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));

        direct("t1", cplx(16384, 0), cplx(8192, 8192), w1, 1'b0, 1'b0,
               cplx(27088, 4434), cplx(5680, -4434), 1'b0);
        direct("t2s0", cplx(32768, 0), cplx(0, -16384), w1, 1'b0, 1'b0,
               cplx(26498, -15137), cplx(39038, 15137), 1'b0);
        direct("t2s1", cplx(32768, 0), cplx(0, -16384), w1, 1'b0, 1'b1,
               cplx(13249, -7568), cplx(19519, 7569), 1'b0);
        direct("t3inv", cplx(16384, 0), cplx(8192, 8192), w1, 1'b1, 1'b0,
               cplx(20818, 10704), cplx(11950, -10704), 1'b0);
        check("pre_ovf_sticky", 64'(ovf_sticky), 64'(0));
        direct("t4ovf", cplx(1048575, 0), cplx(1048575, 0), cplx(32768, 0), 1'b0, 1'b0,
               a4_exp, cplx(0, 0), 1'b1);
        check("t4_sticky", 64'(ovf_sticky), 64'(1));

        // Eight back-to-back beats with a five-cycle downstream stall in the middle.
        n_not_ready = 0;
        pop0 = n_pop;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    drive_beat(rand_data(), rand_data(), rand_twid(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        check("stream_in_ready_dropped", 64'(n_not_ready > 0), 64'(1));
        check("stream_drained", 64'(exp_q.size()), 64'(0));
        check("stream_count", 64'(n_pop - pop0), 64'(8));

        // Reset with three beats in flight: none may reappear.
        for (int i = 0; i < 3; i++)
            drive_beat(rand_data(), rand_data(), rand_twid(), 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_drop_valid", 64'(out_valid), 64'(0));
        check("rst_drop_sticky", 64'(ovf_sticky), 64'(0));
        check("rst_drop_in_ready", 64'(in_ready), 64'(1));
        for (int t = 0; t < 6; t++) begin
            @(posedge clk); #1;
            check("rst_drop_quiet", 64'(out_valid), 64'(0));
        end

        // Randomized stream with input bubbles and random backpressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    drive_beat(rand_data(), rand_data(), rand_twid(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        check("random_drained", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

// File: doc/butterfly_pipe.md
Name: butterfly_pipe

Overview:
- Pipelined, parametrised radix-2 DIT butterfly: A' = A + B·W, B' = A − B·W, complex fixed-point.
- Successor to the combinational butterfly. Adds a valid/ready stream interface, 3-stage pipeline, round-half-up rotation, optional per-stage ÷2 scaling, inverse (conjugate-twiddle) mode and overflow reporting.
- Sits between the twiddle ROM and the stage memories of the FFT datapath. Sustains one butterfly per clock.

Parameters:
- DATA_WIDTH, 21, width of each real/imag component, two's complement.
- FRAC_BITS, 15, fractional bits of data and twiddle (Q(DATA_WIDTH−FRAC_BITS−1).FRAC_BITS).

Ports:
- clk_i  in  1  clock; all logic is rising-edge.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  block can accept a beat.
- twid_i  in  2*DATA_WIDTH  twiddle {im,re}; re in [DATA_WIDTH-1:0].
- a_i  in  2*DATA_WIDTH  operand A {im,re}.
- b_i  in  2*DATA_WIDTH  operand B {im,re}.
- inv_i  in  1  1 = use conj(W) (inverse FFT).
- scale_i  in  1  1 = divide both outputs by 2.
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  downstream accepts beat.
- a_o  out  2*DATA_WIDTH  A' {im,re}.
- b_o  out  2*DATA_WIDTH  B' {im,re}.
- ovf_o  out  1  overflow on the current output beat.
- ovf_sticky_o  out  1  OR of all ovf since reset.

Behaviour:
- Pipeline advance enable: adv = !out_valid_o || out_ready_i.
  - in_ready_o = adv (combinational).
  - All three stages shift only when adv = 1. Stage valid bits travel with the data.
- Input beat accepted when in_valid_i && in_ready_o. Sideband inv_i and scale_i are captured with the beat.
- S1: register a, b, twid, inv, scale. If inv, the registered wi = −twid_im, computed at DATA_WIDTH+1 bits so there is no wrap.
- S2: four full-width signed products br·wr, bi·wi, br·wi, bi·wr, each 2*DATA_WIDTH+1 bits. A is delayed alongside.
- S3 computes in this order:
  - rot_re = (br·wr − bi·wi + 2^(FRAC_BITS−1)) >>> FRAC_BITS.
  - rot_im = (br·wi + bi·wr + 2^(FRAC_BITS−1)) >>> FRAC_BITS.
  - sum = a + rot and dif = a − rot, per component, at DATA_WIDTH+3 bits.
  - If scale: x = (x + 1) >>> 1, i.e. round half up.
  - Each component is then reduced to DATA_WIDTH bits (see Optional Feature).
- No intermediate result wraps; only the final reduction can overflow.
- ovf_o = 1 if any of the 4 components exceeds the DATA_WIDTH range after scaling. ovf_sticky_o sets on any accepted output beat with ovf_o = 1.
- Latency: accepted input to out_valid_o is 3 cycles with no stall. Throughput is 1 beat/cycle.
- Stall: while out_valid_o && !out_ready_i, a_o, b_o and ovf_o hold stable, in_ready_o = 0, and no beat is lost or duplicated.
- Bubbles are allowed: an invalid beat moves through the pipe like a valid one, but its output is never presented.
- Reset: all stage valids, out_valid_o, a_o, b_o, ovf_o and ovf_sticky_o go to 0. In-flight beats are dropped. in_ready_o = 1 the cycle after rst_i deasserts.
- Reset has priority over simultaneous accept/advance.

Optional Feature:
- Macro BUTTERFLY_SAT_EN.
- Defined: overflowing components clamp to +2^(DATA_WIDTH−1)−1 or −2^(DATA_WIDTH−1).
- Undefined: overflowing components keep the low DATA_WIDTH bits, i.e. they wrap.
- ovf_o and ovf_sticky_o behave identically in both builds.

Test Plan:
- W=(30274,−12540), A=(16384,0), B=(8192,8192), inv=0, scale=0 -> rot=(10704,4434), a_o=(27088,4434), b_o=(5680,−4434), ovf_o=0, out_valid_o exactly 3 cycles after accept.
- Same W, A=(32768,0), B=(0,−16384); run once with scale=0 and once with scale=1:
  - scale=0 -> a_o=(26498,−15137), b_o=(39038,15137).
  - scale=1 -> a_o=(13249,−7568), b_o=(19519,7569).
- Test 1 vectors with inv=1 -> a_o=(20818,10704), b_o=(11950,−10704).
- W=(32768,0), A=(1048575,0), B=(1048575,0) -> ovf_o=1, ovf_sticky_o=1, b_o=(0,0).
  - With BUTTERFLY_SAT_EN: a_o.re=1048575.
  - Without BUTTERFLY_SAT_EN: a_o.re=−2.
- Stream 8 back-to-back beats, hold out_ready_i=0 for 5 cycles mid-stream -> in_ready_o drops once the pipe is full, outputs stay stable, all 8 results emerge in order with no loss or duplicates.
- Assert rst_i for 1 cycle with 3 beats in flight -> out_valid_o=0, ovf_sticky_o=0 next cycle, and none of the dropped beats appear afterwards.
